// File: rtl/matrix_multiplier_if.sv
// ----------------------------------------------------------------------------
// matrix_multiplier_if
//   Bundles the operand stream and result bus of matrix_multiplier.
//   Signals:
//     a, b                 operand pair (matrix element, vector element)
//     a_tvalid, b_tvalid   per-operand valid; a term needs both high
//     result0..result3     row dot products
//     done_matrixmult      all four rows complete (sticky until reset)
//   Modports:
//     master  stream source / result consumer (testbench, upstream logic)
//     slave   the multiplier itself
// ----------------------------------------------------------------------------
interface matrix_multiplier_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              a_tvalid;
    logic              b_tvalid;
    logic [DATA_W-1:0] result0;
    logic [DATA_W-1:0] result1;
    logic [DATA_W-1:0] result2;
    logic [DATA_W-1:0] result3;
    logic              done_matrixmult;

    modport master (
        output a, b, a_tvalid, b_tvalid,
        input  result0, result1, result2, result3, done_matrixmult
    );

    modport slave (
        input  a, b, a_tvalid, b_tvalid,
        output result0, result1, result2, result3, done_matrixmult
    );
endinterface

// File: rtl/matrix_multiplier.sv
// ----------------------------------------------------------------------------
// matrix_multiplier
//   Sequential 4x4 matrix by 4-element vector multiplier (result = M * v).
//   One (M[row][k], v[k]) pair is consumed per cycle in which both valids are
//   high; pairs arrive row-major. Each row's dot product is multiply-
//   accumulated and written to its result register on the row's 4th term.
//   After the 16th term the block latches done and ignores all input until
//   reset. Arithmetic is unsigned and wraps modulo 2^DATA_W.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; clears all state
//     bus    matrix_multiplier_if.slave: operands/valids in, results/done out
// ----------------------------------------------------------------------------
module matrix_multiplier #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_multiplier_if.slave    bus
);
    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        row_q, row_d;
    logic [DATA_W-1:0] result_q [4];
    logic [DATA_W-1:0] result_d [4];
    logic              done_q, done_d;

    logic              accept;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] sum;

    // Both operands must be valid in the same cycle; no backpressure exists,
    // so a lone valid is simply dropped.
    assign accept = (state_q == RUN) && bus.a_tvalid && bus.b_tvalid;
    // Assigning to DATA_W-wide nets keeps only the low bits: wrap-around.
    assign prod   = bus.a * bus.b;
    assign sum    = acc_q + prod;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        k_d      = k_q;
        row_d    = row_q;
        result_d = result_q;
        done_d   = done_q;

        if (accept) begin
            if (k_q == 2'd3) begin
                result_d[row_q] = sum;
                acc_d           = '0;
                k_d             = 2'd0;
                row_d           = row_q + 2'd1;
                if (row_q == 2'd3) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                acc_d = sum;
                k_d   = k_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            acc_q   <= '0;
            k_q     <= 2'd0;
            row_q   <= 2'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            row_q    <= row_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.result0         = result_q[0];
    assign bus.result1         = result_q[1];
    assign bus.result2         = result_q[2];
    assign bus.result3         = result_q[3];
    assign bus.done_matrixmult = done_q;
endmodule

// File: tb/tb_matrix_multiplier.sv
module tb_matrix_multiplier;
    localparam int DATA_W = 32;

    logic clk;
    logic reset;

    matrix_multiplier_if #(.DATA_W(DATA_W)) bus ();

    matrix_multiplier #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scenario matrix/vector, row-major, and hand-computed products.
    logic [31:0] m_vals [16] = '{1, 1, 2, 3,
                                 5, 6, 7, 3,
                                 1, 2, 3, 2,
                                 4, 5, 3, 5};
    logic [31:0] v_vals [4]  = '{2, 5, 3, 1};
    logic [31:0] exp_res [4] = '{32'd16, 32'd64, 32'd23, 32'd47};

    // Drives one term for one cycle, then one idle cycle. junk selects what
    // the idle cycle looks like: 0 quiet, 1 a_tvalid only, 2 b_tvalid only.
    task automatic send_term(input logic [31:0] av, input logic [31:0] bv,
                             input int junk);
        @(negedge clk);
        bus.a = av;  bus.b = bv;
        bus.a_tvalid = 1'b1;  bus.b_tvalid = 1'b1;
        @(negedge clk);
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        if (junk != 0) begin
            bus.a = 32'd9;  bus.b = 32'd9;
            bus.a_tvalid = (junk == 1);
            bus.b_tvalid = (junk == 2);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs [4];
        @(negedge clk);
        reset = 1'b1;
        bus.a_tvalid = 1'b1;  bus.b_tvalid = 1'b1;
        bus.a = 32'd3;  bus.b = 32'd4;
        @(negedge clk);
        @(negedge clk);
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_result%0d got=%0d want=0", i, obs[i]);
            end
        end
        total++;
        if (bus.done_matrixmult !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", bus.done_matrixmult);
        end
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        reset = 1'b0;
        $display("test_reset complete");
    endtask

    task automatic test_sequential();
        logic [31:0] obs [4];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_term(m_vals[i], v_vals[i % 4], 0);
            // Row 0 is readable while later rows still run.
            if (i == 3) begin
                total++;
                if (bus.result0 !== 32'd16 || bus.done_matrixmult !== 1'b0) begin
                    bad++;
                    $display("FAIL partial_row0 got=%0d done=%b want=16 done=0",
                             bus.result0, bus.done_matrixmult);
                end
            end
            if (i == 14) begin
                total++;
                if (bus.done_matrixmult !== 1'b0) begin
                    bad++;
                    $display("FAIL early_done got=%b want=0", bus.done_matrixmult);
                end
            end
        end
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs[i] !== exp_res[i]) begin
                bad++;
                $display("FAIL seq_result%0d got=%0d want=%0d", i, obs[i], exp_res[i]);
            end
        end
        total++;
        if (bus.done_matrixmult !== 1'b1) begin
            bad++;
            $display("FAIL seq_done got=%b want=1", bus.done_matrixmult);
        end
        $display("test_sequential results %0d %0d %0d %0d done=%b",
                 obs[0], obs[1], obs[2], obs[3], bus.done_matrixmult);
    endtask

    // Runs straight after test_sequential, while the block sits in DONE.
    task automatic test_hold_after_done();
        logic [31:0] obs [4];
        int          done_drops = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done_matrixmult !== 1'b1) done_drops++;
            bus.a = 32'd7 + c;  bus.b = 32'd11;
            bus.a_tvalid = 1'b1;  bus.b_tvalid = 1'b1;
        end
        @(negedge clk);
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs[i] !== exp_res[i]) begin
                bad++;
                $display("FAIL hold_result%0d got=%0d want=%0d", i, obs[i], exp_res[i]);
            end
        end
        total++;
        if (bus.done_matrixmult !== 1'b1 || done_drops != 0) begin
            bad++;
            $display("FAIL hold_done got=%b drops=%0d want=1 drops=0",
                     bus.done_matrixmult, done_drops);
        end
        $display("test_hold_after_done results %0d %0d %0d %0d", obs[0], obs[1], obs[2], obs[3]);
    endtask

    task automatic test_single_valid();
        logic [31:0] obs [4];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_term(m_vals[i], v_vals[i % 4], (i % 2) + 1);
        end
        @(negedge clk);
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs[i] !== exp_res[i]) begin
                bad++;
                $display("FAIL single_valid_result%0d got=%0d want=%0d", i, obs[i], exp_res[i]);
            end
        end
        total++;
        if (bus.done_matrixmult !== 1'b1) begin
            bad++;
            $display("FAIL single_valid_done got=%b want=1", bus.done_matrixmult);
        end
        $display("test_single_valid results %0d %0d %0d %0d", obs[0], obs[1], obs[2], obs[3]);
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs [4];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_term(m_vals[i], v_vals[i % 4], 0);
        end
        // result0 is 16 here; reset with valids high must clear it anyway.
        @(negedge clk);
        reset = 1'b1;
        bus.a = 32'd5;  bus.b = 32'd5;
        bus.a_tvalid = 1'b1;  bus.b_tvalid = 1'b1;
        @(negedge clk);
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        total++;
        if (obs[0] !== 32'd0 || obs[1] !== 32'd0 || obs[2] !== 32'd0 ||
            obs[3] !== 32'd0 || bus.done_matrixmult !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%0d,%0d,%0d,%0d done=%b want=0,0,0,0 done=0",
                     obs[0], obs[1], obs[2], obs[3], bus.done_matrixmult);
        end
        reset = 1'b0;
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_term(m_vals[i], v_vals[i % 4], 0);
        end
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs[i] !== exp_res[i]) begin
                bad++;
                $display("FAIL replay_result%0d got=%0d want=%0d", i, obs[i], exp_res[i]);
            end
        end
        $display("test_reset_mid results %0d %0d %0d %0d", obs[0], obs[1], obs[2], obs[3]);
    endtask

    task automatic test_wrap();
        logic [31:0] obs [4];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_term(32'hFFFF_FFFF, 32'd2, 0);
        end
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs[i] !== 32'hFFFF_FFF8) begin
                bad++;
                $display("FAIL wrap_result%0d got=%h want=fffffff8", i, obs[i]);
            end
        end
        $display("test_wrap results %h %h %h %h", obs[0], obs[1], obs[2], obs[3]);
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs [4];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            // 15 terms accepted so far: done must still be low.
            if (i == 15) begin
                total++;
                if (bus.done_matrixmult !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_done_early got=%b want=0", bus.done_matrixmult);
                end
            end
            bus.a = m_vals[i];  bus.b = v_vals[i % 4];
            bus.a_tvalid = 1'b1;  bus.b_tvalid = 1'b1;
        end
        @(negedge clk);
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        total++;
        if (bus.done_matrixmult !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done got=%b want=1", bus.done_matrixmult);
        end
        obs = '{bus.result0, bus.result1, bus.result2, bus.result3};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs[i] !== exp_res[i]) begin
                bad++;
                $display("FAIL b2b_result%0d got=%0d want=%0d", i, obs[i], exp_res[i]);
            end
        end
        $display("test_back_to_back results %0d %0d %0d %0d", obs[0], obs[1], obs[2], obs[3]);
    endtask

    initial begin
        reset = 1'b1;
        bus.a = '0;  bus.b = '0;
        bus.a_tvalid = 1'b0;  bus.b_tvalid = 1'b0;
        test_reset();
        test_sequential();
        test_hold_after_done();
        test_single_valid();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
